// File: rtl/heartbeat_gen.sv
// Board heartbeat generator: a continuous square wave or a blink code of N pulses plus a long gap.
// Firmware can force the line stuck high/low. The force port is named force_mode because "force" is a reserved word.
module heartbeat_gen #(
  parameter int PRESCALE   = 1000,
  parameter int HALF_TICKS = 250,
  parameter int GAP_TICKS  = 1000,
  parameter int CNT_WIDTH  = 12
) (
  input  logic       clk,
  input  logic       rst_l,
  input  logic       en,
  input  logic [3:0] code,
  input  logic [1:0] force_mode,
  output logic       out,
  output logic       active,
  output logic       burst_done
);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_HIGH  = 3'd1;
  localparam logic [2:0] ST_LOW   = 3'd2;
  localparam logic [2:0] ST_GAP   = 3'd3;
  localparam logic [2:0] ST_FORCE = 3'd4;

  localparam logic [CNT_WIDTH-1:0] PRE_LAST  = CNT_WIDTH'(PRESCALE - 1);
  localparam logic [CNT_WIDTH-1:0] HALF_LAST = CNT_WIDTH'(HALF_TICKS - 1);
  localparam logic [CNT_WIDTH-1:0] GAP_LAST  = CNT_WIDTH'(GAP_TICKS - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE   = CNT_WIDTH'(1);

  logic [2:0]           state, state_nxt;
  logic [CNT_WIDTH-1:0] presc, presc_nxt;
  logic [CNT_WIDTH-1:0] phase, phase_nxt;
  logic [3:0]           code_q, code_q_nxt;
  logic [3:0]           pulse_cnt, pulse_cnt_nxt;
  logic                 out_nxt, active_nxt, done_nxt;
  logic                 running, running_nxt;
  logic                 tick, half_end, gap_end;

  assign running  = (state == ST_HIGH) || (state == ST_LOW) || (state == ST_GAP);
  assign tick     = running && (presc == PRE_LAST);
  assign half_end = tick && (phase == HALF_LAST);
  assign gap_end  = tick && (phase == GAP_LAST);

  // Force beats enable, enable beats the normal sequencing, in every state.
  always_comb begin
    state_nxt     = state;
    code_q_nxt    = code_q;
    pulse_cnt_nxt = pulse_cnt;
    done_nxt      = 1'b0;
    if (force_mode != 2'b00) begin
      state_nxt = ST_FORCE;
    end else if (!en) begin
      state_nxt = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: begin
          state_nxt     = ST_HIGH;
          code_q_nxt    = code;
          pulse_cnt_nxt = 4'd0;
        end
        ST_HIGH: begin
          if (half_end) state_nxt = ST_LOW;
        end
        ST_LOW: begin
          if (half_end) begin
            if (code_q == 4'd0) begin
              state_nxt = ST_HIGH;
            end else if (pulse_cnt + 4'd1 == code_q) begin
              state_nxt = ST_GAP;
            end else begin
              state_nxt     = ST_HIGH;
              pulse_cnt_nxt = pulse_cnt + 4'd1;
            end
          end
        end
        ST_GAP: begin
          if (gap_end) begin
            state_nxt     = ST_HIGH;
            done_nxt      = 1'b1;
            code_q_nxt    = code;
            pulse_cnt_nxt = 4'd0;
          end
        end
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  // Running-to-running moves only happen on a tick, so the prescaler wraps exactly at each phase boundary.
  always_comb begin
    running_nxt = (state_nxt == ST_HIGH) || (state_nxt == ST_LOW) || (state_nxt == ST_GAP);
    presc_nxt   = '0;
    if (running && running_nxt && !tick) presc_nxt = presc + CNT_ONE;
    phase_nxt = phase;
    if (state_nxt != state) begin
      phase_nxt = '0;
    end else if (tick) begin
      phase_nxt = phase + CNT_ONE;
    end
    out_nxt    = (state_nxt == ST_HIGH) || ((state_nxt == ST_FORCE) && (force_mode == 2'b10));
    active_nxt = running_nxt;
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      state      <= ST_IDLE;
      presc      <= '0;
      phase      <= '0;
      code_q     <= 4'd0;
      pulse_cnt  <= 4'd0;
      out        <= 1'b0;
      active     <= 1'b0;
      burst_done <= 1'b0;
    end else begin
      state      <= state_nxt;
      presc      <= presc_nxt;
      phase      <= phase_nxt;
      code_q     <= code_q_nxt;
      pulse_cnt  <= pulse_cnt_nxt;
      out        <= out_nxt;
      active     <= active_nxt;
      burst_done <= done_nxt;
    end
  end

endmodule

// File: tb/tb_heartbeat_gen.sv
// Bench for heartbeat_gen with PRESCALE=4, HALF_TICKS=3, GAP_TICKS=5: directed scenarios plus random traffic
// checked against a segment-duration reference model.
module tb_heartbeat_gen;

  localparam int PRE  = 4;
  localparam int HALF = 3;
  localparam int GAPT = 5;
  localparam int HP   = HALF * PRE;
  localparam int GP   = GAPT * PRE;

  logic       clk;
  logic       rst_l;
  logic       en;
  logic [3:0] code;
  logic [1:0] force_mode;
  logic       out;
  logic       active;
  logic       burst_done;

  int checks;
  int errors;

  heartbeat_gen #(
    .PRESCALE  (PRE),
    .HALF_TICKS(HALF),
    .GAP_TICKS (GAPT),
    .CNT_WIDTH (4)
  ) dut (
    .clk       (clk),
    .rst_l     (rst_l),
    .en        (en),
    .code      (code),
    .force_mode(force_mode),
    .out       (out),
    .active    (active),
    .burst_done(burst_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: a mode, the current segment, and clocks left in that segment.
  int   m_mode;   // 0 idle, 1 running, 2 forced
  int   m_seg;    // 0 high, 1 low, 2 gap
  int   m_left;
  int   m_pulses;
  int   m_burst;
  logic m_out, m_active, m_done;

  task automatic model_step();
    m_done = 1'b0;
    if (force_mode != 2'b00) begin
      m_mode   = 2;
      m_out    = (force_mode == 2'b10);
      m_active = 1'b0;
    end else if (!en || m_mode == 2) begin
      m_mode   = 0;
      m_out    = 1'b0;
      m_active = 1'b0;
    end else begin
      if (m_mode == 0) begin
        m_mode = 1; m_seg = 0; m_left = HP; m_burst = int'(code); m_pulses = 0;
      end else begin
        m_left = m_left - 1;
        if (m_left == 0) begin
          if (m_seg == 0) begin
            m_seg = 1; m_left = HP;
          end else if (m_seg == 1) begin
            m_pulses = m_pulses + 1;
            if (m_burst != 0 && m_pulses == m_burst) begin
              m_seg = 2; m_left = GP;
            end else begin
              m_seg = 0; m_left = HP;
            end
          end else begin
            m_seg = 0; m_left = HP; m_done = 1'b1; m_burst = int'(code); m_pulses = 0;
          end
        end
      end
      m_out    = (m_seg == 0);
      m_active = 1'b1;
    end
  endtask

  always @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      m_mode = 0; m_seg = 0; m_left = 0; m_pulses = 0; m_burst = 0;
      m_out = 1'b0; m_active = 1'b0; m_done = 1'b0;
    end else begin
      model_step();
    end
  end

  logic h_out [400];
  logic h_act [400];
  logic h_done[400];
  logic e_out [400];
  logic e_act [400];
  logic e_done[400];

  task automatic capture(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      h_out[i] = out;   h_act[i] = active;   h_done[i] = burst_done;
      e_out[i] = m_out; e_act[i] = m_active; e_done[i] = m_done;
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++;
    if ({out, active, burst_done} !== 3'b000) begin
      errors++;
      $display("FAIL reset got out/active/done=%b%b%b expected 000", out, active, burst_done);
    end
    rst_l = 1'b1;
    capture(3);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if ({h_out[i], h_act[i], h_done[i]} !== 3'b000) begin
        errors++;
        $display("FAIL reset_idle[%0d] got %b%b%b expected 000", i, h_out[i], h_act[i], h_done[i]);
      end
    end
  endtask

  task automatic test_continuous();
    code = 4'd0; en = 1'b1;
    capture(72);
    for (int i = 0; i < 72; i++) begin
      checks++;
      if ({h_out[i], h_act[i], h_done[i]} !== {((i / HP) % 2 == 0), 1'b1, 1'b0}) begin
        errors++;
        $display("FAIL continuous[%0d] got %b%b%b expected %b10", i, h_out[i], h_act[i], h_done[i],
                 ((i / HP) % 2 == 0));
      end
      checks++;
      if ({h_out[i], h_act[i], h_done[i]} !== {e_out[i], e_act[i], e_done[i]}) begin
        errors++;
        $display("FAIL model_continuous[%0d] got %b%b%b expected %b%b%b", i, h_out[i], h_act[i], h_done[i],
                 e_out[i], e_act[i], e_done[i]);
      end
    end
  endtask

  task automatic test_coded();
    int j;
    en = 1'b0; capture(1);
    code = 4'd2; en = 1'b1;
    capture(140);
    for (int i = 0; i < 140; i++) begin
      j = i % 68;
      checks++;
      if ({h_out[i], h_act[i], h_done[i]} !== {(j < 12 || (j >= 24 && j < 36)), 1'b1, (j == 0 && i > 0)}) begin
        errors++;
        $display("FAIL coded[%0d] got %b%b%b expected %b1%b", i, h_out[i], h_act[i], h_done[i],
                 (j < 12 || (j >= 24 && j < 36)), (j == 0 && i > 0));
      end
      checks++;
      if ({h_out[i], h_act[i], h_done[i]} !== {e_out[i], e_act[i], e_done[i]}) begin
        errors++;
        $display("FAIL model_coded[%0d] got %b%b%b expected %b%b%b", i, h_out[i], h_act[i], h_done[i],
                 e_out[i], e_act[i], e_done[i]);
      end
    end
  endtask

  task automatic test_code_change();
    int d1, d2, r1, r2;
    en = 1'b0; capture(1);
    code = 4'd2; en = 1'b1;
    capture(5);
    code = 4'd5;
    capture(300);
    d1 = -1; d2 = -1; r1 = 0; r2 = 0;
    for (int k = 0; k < 300; k++) begin
      checks++;
      if ({h_out[k], h_act[k], h_done[k]} !== {e_out[k], e_act[k], e_done[k]}) begin
        errors++;
        $display("FAIL model_code_change[%0d] got %b%b%b expected %b%b%b", k, h_out[k], h_act[k], h_done[k],
                 e_out[k], e_act[k], e_done[k]);
      end
      if (h_done[k] === 1'b1) begin
        if (d1 < 0) d1 = k;
        else if (d2 < 0) d2 = k;
      end
      if (k > 0 && h_out[k] === 1'b1 && h_out[k-1] === 1'b0) begin
        if (d1 < 0) r1++;
        else if (d2 < 0) r2++;
      end
    end
    checks++;
    if (d1 != 63) begin errors++; $display("FAIL code_change_done1 got %0d expected 63", d1); end
    checks++;
    if (d2 != 203) begin errors++; $display("FAIL code_change_done2 got %0d expected 203", d2); end
    checks++;
    if (r1 != 1) begin errors++; $display("FAIL code_change_old_rises got %0d expected 1", r1); end
    checks++;
    if (r2 != 5) begin errors++; $display("FAIL code_change_new_pulses got %0d expected 5", r2); end
  endtask

  task automatic test_force();
    logic [1:0] fv;
    for (int k = 0; k < 3; k++) begin
      fv = (k == 0) ? 2'b10 : ((k == 1) ? 2'b01 : 2'b11);
      en = 1'b0; capture(1);
      code = 4'd0; en = 1'b1;
      capture($urandom_range(13, 22));
      force_mode = fv;
      capture(30);
      for (int i = 0; i < 30; i++) begin
        checks++;
        if ({h_out[i], h_act[i], h_done[i]} !== {(fv == 2'b10), 1'b0, 1'b0}) begin
          errors++;
          $display("FAIL force_hold %b [%0d] got %b%b%b expected %b00", fv, i, h_out[i], h_act[i], h_done[i],
                   (fv == 2'b10));
        end
      end
      force_mode = 2'b00;
      capture(15);
      for (int i = 0; i < 15; i++) begin
        checks++;
        if ({h_out[i], h_act[i], h_done[i]} !== {(i >= 1 && i <= 12), (i >= 1), 1'b0}) begin
          errors++;
          $display("FAIL force_release %b [%0d] got %b%b%b expected %b%b0", fv, i, h_out[i], h_act[i],
                   h_done[i], (i >= 1 && i <= 12), (i >= 1));
        end
      end
    end
  endtask

  task automatic test_en_drop();
    en = 1'b0; capture(1);
    code = 4'($urandom_range(0, 15)); en = 1'b1;
    capture(5);
    en = 1'b0;
    capture(3);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if ({h_out[i], h_act[i], h_done[i]} !== 3'b000) begin
        errors++;
        $display("FAIL en_drop[%0d] got %b%b%b expected 000", i, h_out[i], h_act[i], h_done[i]);
      end
    end
    en = 1'b1;
    capture(14);
    for (int i = 0; i < 14; i++) begin
      checks++;
      if ({h_out[i], h_act[i], h_done[i]} !== {(i < 12), 1'b1, 1'b0}) begin
        errors++;
        $display("FAIL en_restart[%0d] got %b%b%b expected %b10", i, h_out[i], h_act[i], h_done[i], (i < 12));
      end
    end
  endtask

  task automatic test_async_reset();
    en = 1'b0; capture(1);
    code = 4'd1; en = 1'b1;
    capture(32);
    checks++;
    if ({h_out[31], h_act[31]} !== 2'b01) begin
      errors++;
      $display("FAIL pre_reset_gap got out/active=%b%b expected 01", h_out[31], h_act[31]);
    end
    #3 rst_l = 1'b0;
    #1;
    checks++;
    if ({out, active, burst_done} !== 3'b000) begin
      errors++;
      $display("FAIL async_reset got %b%b%b expected 000", out, active, burst_done);
    end
    @(negedge clk);
    rst_l = 1'b1;
    capture(14);
    for (int i = 0; i < 14; i++) begin
      checks++;
      if ({h_out[i], h_act[i], h_done[i]} !== {(i < 12), 1'b1, 1'b0}) begin
        errors++;
        $display("FAIL reset_restart[%0d] got %b%b%b expected %b10", i, h_out[i], h_act[i], h_done[i], (i < 12));
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      checks++;
      if ({out, active, burst_done} !== {m_out, m_active, m_done}) begin
        errors++;
        $display("FAIL random[%0d] got %b%b%b expected %b%b%b", i, out, active, burst_done,
                 m_out, m_active, m_done);
      end
      if (force_mode != 2'b00) begin
        if ($urandom_range(0, 9) == 0) force_mode = 2'b00;
      end else if ($urandom_range(0, 199) == 0) begin
        force_mode = 2'($urandom_range(1, 3));
      end
      if (!en) begin
        if ($urandom_range(0, 9) == 0) en = 1'b1;
      end else if ($urandom_range(0, 149) == 0) begin
        en = 1'b0;
      end
      if ($urandom_range(0, 29) == 0) code = 4'($urandom_range(0, 3));
    end
  endtask

  initial begin
    checks = 0; errors = 0;
    rst_l = 1'b0; en = 1'b0; code = 4'd0; force_mode = 2'b00;
    test_reset();
    test_continuous();
    test_coded();
    test_code_change();
    test_force();
    test_en_drop();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
